// File: rtl/ifu.sv
// Instruction fetch unit for the multicycle MIPS datapath.
// Owns the PC and next-PC logic, addresses the synchronous instruction memory
// and captures its read data into the instruction register.
//
// Ports:
//   clk       system clock, all state updates on posedge
//   rst       asynchronous active-high reset
//   fetch     fetch request at current pc (sampled only when idle)
//   pc_wr     PC update request selected by npc_sel (sampled only when idle)
//   npc_sel   00 pc+4, 01 branch, 10 jump, 11 jr
//   br_taken  branch condition, qualifies npc_sel = 01
//   rs_data   jr target
//   im_addr   word address to instruction memory (pc[11:2])
//   im_dout   instruction memory read data
//   pc        next instruction address
//   pc_cur    address of the instruction held in ir
//   ir        instruction register
//   ir_valid  one-cycle pulse after ir is loaded
//   busy      fetch in progress
module ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic        pc_wr,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] rs_data,
    output logic [9:0]  im_addr,
    input  logic [31:0] im_dout,
    output logic [31:0] pc,
    output logic [31:0] pc_cur,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRead, StLoad} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_cur_q, pc_cur_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;

    logic [31:0] br_off;
    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= PC_RESET;
            pc_cur_q   <= PC_RESET;
            ir_q       <= 32'h0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_cur_q   <= pc_cur_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_cur_d   = pc_cur_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pc_wr) begin
                    unique case (npc_sel)
                        2'b00: pc_d = pc_q + 32'd4;
                        2'b01: if (br_taken) pc_d = pc_q + br_off;
                        2'b10: pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                        2'b11: pc_d = {rs_data[31:2], 2'b00};
                        default: pc_d = pc_q;
                    endcase
                end
                // A simultaneous pc_wr lands at the same edge, so the read
                // in StRead uses the updated pc.
                if (fetch) state_d = StRead;
            end
            // Memory samples im_addr at the edge leaving StRead; pc is held.
            StRead: state_d = StLoad;
            StLoad: begin
                state_d    = StIdle;
                ir_d       = im_dout;
                pc_cur_d   = pc_q;
                pc_d       = pc_q + 32'd4;
                ir_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign im_addr  = pc_q[11:2];
    assign pc       = pc_q;
    assign pc_cur   = pc_cur_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch;
    logic        pc_wr;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] rs_data;
    logic [9:0]  im_addr;
    logic [31:0] im_dout;
    logic [31:0] pc;
    logic [31:0] pc_cur;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Synchronous instruction memory
    logic [31:0] mem [1024];
    always @(posedge clk) im_dout <= mem[im_addr];

    // Reference state
    logic [31:0] m_pc, m_pc_cur, m_ir;

    ifu #(.PC_RESET(32'h0000_3000)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch    (fetch),
        .pc_wr    (pc_wr),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .rs_data  (rs_data),
        .im_addr  (im_addr),
        .im_dout  (im_dout),
        .pc       (pc),
        .pc_cur   (pc_cur),
        .ir       (ir),
        .ir_valid (ir_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0000_3000;
        m_pc_cur = 32'h0000_3000;
        m_ir     = 32'h0;
    endtask

    task automatic model_pcwr(input logic [1:0] sel, input bit taken, input logic [31:0] rs);
        int off;
        case (sel)
            2'd0: m_pc = m_pc + 32'd4;
            2'd1: begin
                off = $signed(m_ir[15:0]);
                if (taken) m_pc = m_pc + 32'(off * 4);
            end
            2'd2: m_pc = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
            default: m_pc = rs & ~32'd3;
        endcase
    endtask

    task automatic model_fetch();
        m_ir     = mem[(m_pc / 4) % 1024];
        m_pc_cur = m_pc;
        m_pc     = m_pc + 32'd4;
    endtask

    // One idle-state command, followed by a full fetch when f is set.
    // Junk commands are driven during the busy cycles and must be ignored.
    task automatic step(input bit f, input bit w, input logic [1:0] sel, input bit taken,
                        input logic [31:0] rs);
        fetch = f; pc_wr = w; npc_sel = sel; br_taken = taken; rs_data = rs;
        @(posedge clk); #1;
        fetch = 1'b0; pc_wr = 1'b0;
        if (w) model_pcwr(sel, taken, rs);
        check("pc_after_cmd", pc, m_pc);
        check("busy_after_cmd", 32'(busy), 32'(f));
        if (f) begin
            check("im_addr_read", 32'(im_addr), (m_pc >> 2) & 32'h3FF);
            check("ir_valid_read", 32'(ir_valid), 32'd0);
            fetch = 1'($urandom); pc_wr = 1'($urandom);
            npc_sel = 2'($urandom); br_taken = 1'($urandom); rs_data = $urandom;
            @(posedge clk); #1;
            check("pc_hold_load", pc, m_pc);
            check("busy_load", 32'(busy), 32'd1);
            fetch = 1'($urandom); pc_wr = 1'($urandom);
            npc_sel = 2'($urandom); rs_data = $urandom;
            @(posedge clk); #1;
            fetch = 1'b0; pc_wr = 1'b0;
            model_fetch();
            check("ir", ir, m_ir);
            check("pc_cur", pc_cur, m_pc_cur);
            check("pc_after_fetch", pc, m_pc);
            check("ir_valid_pulse", 32'(ir_valid), 32'd1);
            check("busy_done", 32'(busy), 32'd0);
            @(posedge clk); #1;
            check("ir_valid_drop", 32'(ir_valid), 32'd0);
            check("pc_idle_hold", pc, m_pc);
        end
    endtask

    initial begin
        bit f, w;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        rst = 1'b0; fetch = 1'b0; pc_wr = 1'b0; npc_sel = 2'd0;
        br_taken = 1'b0; rs_data = 32'h0;

        // Reset asserted mid-cycle takes effect without a clock edge
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_im_addr", 32'(im_addr), 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Sequential fetch
        step(1, 0, 2'd0, 0, 0);
        check("seq1_ir", ir, 32'h2008_0005);
        check("seq1_pc_cur", pc_cur, 32'h0000_3000);
        check("seq1_pc", pc, 32'h0000_3004);
        step(1, 0, 2'd0, 0, 0);
        check("seq2_ir", ir, 32'h2009_0003);
        check("seq2_pc", pc, 32'h0000_3008);

        // Branch: load 0x1000FFFE from 0x3004 so pc becomes 0x3008
        mem[1] = 32'h1000_FFFE;
        mem[2] = 32'h0800_0C10;
        step(1, 1, 2'd3, 0, 32'h0000_3004);
        check("br_ir", ir, 32'h1000_FFFE);
        check("br_pc_pre", pc, 32'h0000_3008);
        step(0, 1, 2'd1, 1, 0);
        check("br_taken_pc", pc, 32'h0000_3000);
        step(0, 1, 2'd3, 0, 32'h0000_3008);
        step(0, 1, 2'd1, 0, 0);
        check("br_not_taken_pc", pc, 32'h0000_3008);

        // Jump and jr
        step(1, 0, 2'd0, 0, 0);
        check("j_ir", ir, 32'h0800_0C10);
        step(0, 1, 2'd2, 0, 0);
        check("j_pc", pc, 32'h0000_3040);
        step(0, 1, 2'd3, 0, 32'h0000_301F);
        check("jr_pc", pc, 32'h0000_301C);
        check("jr_im_addr", 32'(im_addr), 32'h007);

        // Simultaneous fetch + pc_wr; junk during busy cycles inside step
        step(1, 1, 2'd3, 0, 32'h0000_3010);
        check("sim_ir", ir, mem[4]);
        check("sim_pc_cur", pc_cur, 32'h0000_3010);
        check("sim_pc", pc, 32'h0000_3014);

        // Reset during LOAD: no ir_valid pulse, state cleared
        fetch = 1'b1;
        @(posedge clk); #1;
        fetch = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_load", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_pc", pc, m_pc);
        check("mid_rst_ir", ir, m_ir);
        check("mid_rst_pc_cur", pc_cur, m_pc_cur);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_no_pulse", 32'(ir_valid), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_no_pulse2", 32'(ir_valid), 32'd0);
        step(1, 0, 2'd0, 0, 0);
        check("post_rst_ir", ir, mem[0]);

        // Randomised command mix
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 1023)] = $urandom;
            f = 1'($urandom);
            w = 1'($urandom);
            step(f, w, 2'($urandom), 1'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
